// File: rtl/ext_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_pkg
// Description : Shared types and defaults for the external-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_mem_pkg;

    localparam int          WORD_SIZE_DEF = 32;
    localparam int          LATENCY_DEF   = 4;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage : ext_mem_pkg
`default_nettype wire

// File: rtl/ext_mem_stall_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_stall_lfsr
// Description : 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise
//               the responder's stall length.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_stall_lfsr
    import ext_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    assign lfsr = r_lfsr;

endmodule : ext_mem_stall_lfsr
`default_nettype wire

// File: rtl/ext_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_responder
// Description : Word-addressed RAM answering single-word cache reads/writes
//               with a one-cycle ack after a configurable stall; flags
//               misaligned, out-of-range and re/wr-conflict requests.
//               Optional macro EXT_MEM_RANDOM_STALL_EN adds 0-3 random
//               stall cycles per request.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int ADDR_BITS = 14,
    parameter int LATENCY   = LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          ext_addr,
    input  logic [WORD_SIZE-1:0] ext_data_in,
    input  logic                 ext_re,
    input  logic                 ext_wr,
    output logic [WORD_SIZE-1:0] ext_data_out,
    output logic                 ext_ack,
    output logic                 ext_err
);

    // Counter must hold LATENCY-1 plus up to three random extra cycles.
    localparam int CNT_W = $clog2(LATENCY + 4) + 1;
    localparam int DEPTH = 2 ** ADDR_BITS;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CNT_W-1:0]       r_cnt;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic                   r_is_wr;
    logic                   r_is_err;

    logic [WORD_SIZE-1:0]   r_mem [DEPTH];

    logic                   r_ack;
    logic                   r_err;
    logic [WORD_SIZE-1:0]   r_rdata;

    logic                   w_req;
    logic                   w_accept;
    logic                   w_busy_done;
    logic                   w_req_err;
    logic [1:0]             w_extra;
    logic [CNT_W-1:0]       w_cnt_init;

`ifdef EXT_MEM_RANDOM_STALL_EN
    logic [15:0]            w_lfsr;

    ext_mem_stall_lfsr u_stall_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (w_lfsr)
    );

    assign w_extra = w_lfsr[1:0];
`else
    assign w_extra = 2'b00;
`endif

    assign w_req       = ext_re | ext_wr;
    assign w_accept    = (r_state == IDLE) && w_req;
    assign w_busy_done = (r_state == BUSY) && (r_cnt == '0);
    assign w_cnt_init  = CNT_W'(LATENCY - 1) + CNT_W'(w_extra);

    // Any address bit above the RAM's byte range makes the request invalid.
    assign w_req_err = (ext_re && ext_wr)
                    || (ext_addr[1:0] != 2'b00)
                    || ((ext_addr >> (ADDR_BITS + 2)) != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_nxt = BUSY;
            BUSY:    if (r_cnt == '0) w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture and stall countdown; inputs are ignored after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_is_wr  <= 1'b0;
            r_is_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= w_cnt_init;
            r_idx    <= ext_addr[ADDR_BITS+1:2];
            r_wdata  <= ext_data_in;
            r_is_wr  <= ext_wr;
            r_is_err <= w_req_err;
        end else if ((r_state == BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Outputs are registered on the edge entering ACK, so they are high
    // exactly while the FSM sits in ACK and cleared on the way out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            if (w_busy_done) begin
                r_ack <= 1'b1;
                r_err <= r_is_err;
                if (!r_is_err && !r_is_wr) begin
                    r_rdata <= r_mem[r_idx];
                end
            end
        end
    end

    // RAM contents survive rst; a reset in the ACK cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == ACK) && r_is_wr && !r_is_err) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign ext_ack      = r_ack;
    assign ext_err      = r_err;
    assign ext_data_out = r_rdata;

endmodule : ext_mem_responder
`default_nettype wire
